hazard_scoreboard: RTL and testbench

- Parametrised successor hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Covers GPR forwarding, branch forwarding in D, and HI/LO forwarding.
- Handles load-use and branch stalls, with load latency as a parameter.
- Owns the multi-cycle divider stall via an internal counter FSM, replacing the external stall_div input.
- Adds exception flush and a saturating stall-cycle counter.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/div_stall_ctrl.sv | 87 ++++++++
 rtl/hazard_scoreboard.sv | 147 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit and the datapath forwarding muxes.
//   fwd_sel_t   : forward-select encoding (register file / W stage / M stage)
//   div_state_e : divider stall controller states
//   fwd_pick    : priority encoder, M-stage hit wins over W-stage hit
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_W  = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic fwd_sel_t fwd_pick(input logic hit_m, input logic hit_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/div_stall_ctrl.sv
// Multi-cycle divider stall controller.
// Holds the divide in E for exactly DIV_CYCLES cycles (the IDLE cycle in
// which div_startE is first seen, plus DIV_CYCLES-1 BUSY cycles), then
// spends one DONE cycle in which E advances.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   div_startE  : div/divu sitting in E (held for the whole divide)
//   excM        : exception in M, aborts any divide in progress
//   divStall    : raw divide stall request (not yet masked by excM)
//   div_busy    : registered, high in BUSY
//   div_done    : registered, high for the single DONE cycle
module div_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_startE,
  input  logic excM,
  output logic divStall,
  output logic div_busy,
  output logic div_done
);

  localparam int unsigned CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 2);

  div_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          div_busy_q;
  logic          div_done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      div_busy_q <= 1'b0;
      div_done_q <= 1'b0;
    end else if (excM) begin
      // The excepting instruction (or an older one) kills the divide.
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      div_busy_q <= 1'b0;
      div_done_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (div_startE) begin
            state_q    <= DIV_BUSY;
            cnt_q      <= CNT_LOAD;
            div_busy_q <= 1'b1;
          end
        end
        DIV_BUSY: begin
          if (cnt_q == '0) begin
            state_q    <= DIV_DONE;
            div_busy_q <= 1'b0;
            div_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DIV_DONE: begin
          // div_startE is still high from the finishing divide; ignore it.
          state_q    <= DIV_IDLE;
          div_done_q <= 1'b0;
        end
        default: begin
          state_q    <= DIV_IDLE;
          cnt_q      <= '0;
          div_busy_q <= 1'b0;
          div_done_q <= 1'b0;
        end
      endcase
    end
  end

  // The first stall cycle comes straight from div_startE so the divide is
  // held in E from the very cycle it arrives.
  assign divStall = ((state_q == DIV_IDLE) && div_startE) || (state_q == DIV_BUSY);
  assign div_busy = div_busy_q;
  assign div_done = div_done_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
// Forwarding: GPR operands in E (from M or W), branch operands in D (from M),
// HI/LO in E (from M or W). Stalls: load-use, branch-operand, divide.
// An exception in M flushes D/E/M and cancels every stall.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   rsD, rtD, branchD            : D-stage sources, branch flag
//   rsE, rtE, writeRegE          : E-stage sources / destination
//   regWriteE, memToRegE         : E-stage GPR write / load
//   div_startE                   : divide in E
//   writeRegM, regWriteM, memToRegM, hilo_weM : M-stage controls
//   writeRegW, regWriteW, hilo_weW            : W-stage controls
//   excM                         : exception detected in M
//   forwardAD/BD                 : branch comparator operand from M
//   forwardAE/BE/HiloE           : fwd_sel_t operand selects for E
//   stallF/D/E, flushD/E/M       : pipeline register hold / bubble
//   div_busy, div_done           : divider controller status
//   stall_cnt                    : saturating count of cycles with stallF
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REGW       = 5,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REGW-1:0]  rsD,
  input  logic [REGW-1:0]  rtD,
  input  logic             branchD,
  input  logic [REGW-1:0]  rsE,
  input  logic [REGW-1:0]  rtE,
  input  logic [REGW-1:0]  writeRegE,
  input  logic             regWriteE,
  input  logic             memToRegE,
  input  logic             div_startE,
  input  logic [REGW-1:0]  writeRegM,
  input  logic             regWriteM,
  input  logic             memToRegM,
  input  logic             hilo_weM,
  input  logic [REGW-1:0]  writeRegW,
  input  logic             regWriteW,
  input  logic             hilo_weW,
  input  logic             excM,
  output logic             forwardAD,
  output logic             forwardBD,
  output fwd_sel_t         forwardAE,
  output fwd_sel_t         forwardBE,
  output fwd_sel_t         forwardHiloE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cnt
);

  // ---------------------------------------------------------------------
  // Forwarding: a source hits a stage only when it is not $0, names that
  // stage's destination and that stage actually writes the register file.
  // ---------------------------------------------------------------------
  logic rsE_hit_m, rsE_hit_w, rtE_hit_m, rtE_hit_w;

  assign rsE_hit_m = (rsE != '0) && (rsE == writeRegM) && regWriteM;
  assign rsE_hit_w = (rsE != '0) && (rsE == writeRegW) && regWriteW;
  assign rtE_hit_m = (rtE != '0) && (rtE == writeRegM) && regWriteM;
  assign rtE_hit_w = (rtE != '0) && (rtE == writeRegW) && regWriteW;

  assign forwardAE    = fwd_pick(rsE_hit_m, rsE_hit_w);
  assign forwardBE    = fwd_pick(rtE_hit_m, rtE_hit_w);
  assign forwardHiloE = fwd_pick(hilo_weM, hilo_weW);

  assign forwardAD = (rsD != '0) && (rsD == writeRegM) && regWriteM;
  assign forwardBD = (rtD != '0) && (rtD == writeRegM) && regWriteM;

  // ---------------------------------------------------------------------
  // Stall terms
  // ---------------------------------------------------------------------
  logic lw_stall_e, lw_stall_m, lw_stall, branch_stall;
  logic div_stall;

  assign lw_stall_e = memToRegE && ((rsD == rtE) || (rtD == rtE));

  // With a two-stage load the data is not forwardable while the load is in
  // M, so dependents in D wait one more cycle.
  assign lw_stall_m = (LOAD_LAT >= 2) && memToRegM &&
                      (((rsD != '0) && (rsD == writeRegM)) ||
                       ((rtD != '0) && (rtD == writeRegM)));

  assign lw_stall = lw_stall_e || lw_stall_m;

  assign branch_stall = branchD &&
    ((regWriteE && ((writeRegE == rsD) || (writeRegE == rtD))) ||
     (memToRegM && ((writeRegM == rsD) || (writeRegM == rtD))));

  div_stall_ctrl #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_stall_ctrl (
    .clk        (clk),
    .rst        (rst),
    .div_startE (div_startE),
    .excM       (excM),
    .divStall   (div_stall),
    .div_busy   (div_busy),
    .div_done   (div_done)
  );

  // ---------------------------------------------------------------------
  // Pipeline control. excM overrides everything: all stalls drop and
  // D, E and M are bubbled. E is never bubbled while a divide holds it.
  // ---------------------------------------------------------------------
  assign stallF = (lw_stall || branch_stall || div_stall) && !excM;
  assign stallD = stallF;
  assign stallE = div_stall && !excM;
  assign flushE = ((lw_stall || branch_stall) && !div_stall) || excM;
  assign flushD = excM;
  assign flushM = excM;

  // ---------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // NOTE: the default assignment first keeps this block purely
  // combinational; without it the hold case would infer a latch.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two hazard units (LOAD_LAT=1 and LOAD_LAT=2) share all
// inputs. The driver computes expected outputs from a behavioural model and
// pushes them into per-instance queues; a monitor pops and compares on every
// falling edge.
module tb_hazard_scoreboard;

  localparam int DIVC = 4;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic branchD, regWriteE, memToRegE, div_startE;
    logic regWriteM, memToRegM, hilo_weM, regWriteW, hilo_weW, excM;
  } stim_t;

  typedef struct {
    logic        fAD, fBD;
    logic [1:0]  fAE, fBE, fH;
    logic        stallF, stallD, stallE, flushD, flushE, flushM, busy, done;
    logic [31:0] cnt;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic branchD, regWriteE, memToRegE, div_startE;
  logic regWriteM, memToRegM, hilo_weM, regWriteW, hilo_weW, excM;

  logic       o_fAD [2], o_fBD [2];
  logic [1:0] o_fAE [2], o_fBE [2], o_fH [2];
  logic       o_stF [2], o_stD [2], o_stE [2], o_flD [2], o_flE [2], o_flM [2];
  logic       o_busy [2], o_done [2];
  logic [CNTW-1:0] o_cnt [2];

  int n_cmp  = 0;
  int n_fail = 0;

  resp_t exp_q0 [$];
  resp_t exp_q1 [$];

  // Model state: remaining BUSY cycles, DONE flag, stall count.
  int m_busy_rem [2];
  bit m_done     [2];
  int m_cnt      [2];

  always #5 clk = ~clk;

  hazard_scoreboard #(.REGW(5), .LOAD_LAT(1), .DIV_CYCLES(DIVC), .CNT_W(CNTW)) dut0 (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE), .regWriteE(regWriteE),
    .memToRegE(memToRegE), .div_startE(div_startE), .writeRegM(writeRegM),
    .regWriteM(regWriteM), .memToRegM(memToRegM), .hilo_weM(hilo_weM),
    .writeRegW(writeRegW), .regWriteW(regWriteW), .hilo_weW(hilo_weW), .excM(excM),
    .forwardAD(o_fAD[0]), .forwardBD(o_fBD[0]), .forwardAE(o_fAE[0]),
    .forwardBE(o_fBE[0]), .forwardHiloE(o_fH[0]), .stallF(o_stF[0]),
    .stallD(o_stD[0]), .stallE(o_stE[0]), .flushD(o_flD[0]), .flushE(o_flE[0]),
    .flushM(o_flM[0]), .div_busy(o_busy[0]), .div_done(o_done[0]), .stall_cnt(o_cnt[0])
  );

  hazard_scoreboard #(.REGW(5), .LOAD_LAT(2), .DIV_CYCLES(DIVC), .CNT_W(CNTW)) dut1 (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD),
    .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE), .regWriteE(regWriteE),
    .memToRegE(memToRegE), .div_startE(div_startE), .writeRegM(writeRegM),
    .regWriteM(regWriteM), .memToRegM(memToRegM), .hilo_weM(hilo_weM),
    .writeRegW(writeRegW), .regWriteW(regWriteW), .hilo_weW(hilo_weW), .excM(excM),
    .forwardAD(o_fAD[1]), .forwardBD(o_fBD[1]), .forwardAE(o_fAE[1]),
    .forwardBE(o_fBE[1]), .forwardHiloE(o_fH[1]), .stallF(o_stF[1]),
    .stallD(o_stD[1]), .stallE(o_stE[1]), .flushD(o_flD[1]), .flushE(o_flE[1]),
    .flushM(o_flM[1]), .div_busy(o_busy[1]), .div_done(o_done[1]), .stall_cnt(o_cnt[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic logic [1:0] fwd_src(logic [4:0] src, logic [4:0] wm, logic rwm,
                                         logic [4:0] ww, logic rww);
    if (src == 0) return 2'd0;
    if (rwm && src == wm) return 2'd2;
    if (rww && src == ww) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit reads(logic [4:0] r, logic [4:0] a, logic [4:0] b);
    return (r == a) || (r == b);
  endfunction

  function automatic resp_t model(stim_t s, int lat, int d);
    resp_t r;
    bit lw, br, dv;
    r.fAE = fwd_src(s.rsE, s.writeRegM, s.regWriteM, s.writeRegW, s.regWriteW);
    r.fBE = fwd_src(s.rtE, s.writeRegM, s.regWriteM, s.writeRegW, s.regWriteW);
    r.fH  = s.hilo_weM ? 2'd2 : (s.hilo_weW ? 2'd1 : 2'd0);
    r.fAD = (s.rsD != 0) && s.regWriteM && (s.rsD == s.writeRegM);
    r.fBD = (s.rtD != 0) && s.regWriteM && (s.rtD == s.writeRegM);
    lw = s.memToRegE && reads(s.rtE, s.rsD, s.rtD);
    if (lat == 2 && s.memToRegM && s.writeRegM != 0 && reads(s.writeRegM, s.rsD, s.rtD))
      lw = 1;
    br = s.branchD && ((s.regWriteE && reads(s.writeRegE, s.rsD, s.rtD)) ||
                       (s.memToRegM && reads(s.writeRegM, s.rsD, s.rtD)));
    dv = (m_busy_rem[d] > 0) || (!m_done[d] && s.div_startE);
    if (s.excM) begin
      r.stallF = 0; r.stallD = 0; r.stallE = 0;
      r.flushD = 1; r.flushE = 1; r.flushM = 1;
    end else begin
      r.stallF = lw || br || dv;
      r.stallD = r.stallF;
      r.stallE = dv;
      r.flushD = 0; r.flushM = 0;
      r.flushE = (lw || br) && !dv;
    end
    r.busy = m_busy_rem[d] > 0;
    r.done = m_done[d];
    r.cnt  = 32'(m_cnt[d]);
    return r;
  endfunction

  task automatic model_step(int d, stim_t s, resp_t r);
    if (s.excM) begin
      m_busy_rem[d] = 0;
      m_done[d]     = 0;
    end else if (m_done[d]) begin
      m_done[d] = 0;
    end else if (m_busy_rem[d] > 0) begin
      if (m_busy_rem[d] == 1) m_done[d] = 1;
      m_busy_rem[d]--;
    end else if (s.div_startE) begin
      m_busy_rem[d] = DIVC - 1;
    end
    if (r.stallF && m_cnt[d] < CMAX) m_cnt[d]++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy_rem[d] = 0; m_done[d] = 0; m_cnt[d] = 0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_inputs(stim_t s);
    rsD = s.rsD; rtD = s.rtD; branchD = s.branchD;
    rsE = s.rsE; rtE = s.rtE; writeRegE = s.writeRegE;
    regWriteE = s.regWriteE; memToRegE = s.memToRegE; div_startE = s.div_startE;
    writeRegM = s.writeRegM; regWriteM = s.regWriteM; memToRegM = s.memToRegM;
    hilo_weM = s.hilo_weM; writeRegW = s.writeRegW; regWriteW = s.regWriteW;
    hilo_weW = s.hilo_weW; excM = s.excM;
  endtask

  function automatic stim_t zero_stim();
    stim_t s;
    s.rsD = 0; s.rtD = 0; s.rsE = 0; s.rtE = 0;
    s.writeRegE = 0; s.writeRegM = 0; s.writeRegW = 0;
    s.branchD = 0; s.regWriteE = 0; s.memToRegE = 0; s.div_startE = 0;
    s.regWriteM = 0; s.memToRegM = 0; s.hilo_weM = 0;
    s.regWriteW = 0; s.hilo_weW = 0; s.excM = 0;
    return s;
  endfunction

  // Applies one cycle of stimulus (called just after a rising edge) and
  // records the expected response for the monitor.
  task automatic apply(stim_t s);
    resp_t e0, e1;
    set_inputs(s);
    e0 = model(s, 1, 0);
    e1 = model(s, 2, 1);
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
    model_step(0, s, e0);
    model_step(1, s, e1);
  endtask

  task automatic cyc_begin(stim_t s);
    apply(s);
    @(negedge clk);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    model_reset();
    set_inputs(zero_stim());
    @(negedge clk);
    rst = 1'b0;
    cyc_end();
  endtask

  // ---------------- monitor ----------------
  function automatic resp_t sample(int d);
    resp_t r;
    r.fAD = o_fAD[d]; r.fBD = o_fBD[d];
    r.fAE = o_fAE[d]; r.fBE = o_fBE[d]; r.fH = o_fH[d];
    r.stallF = o_stF[d]; r.stallD = o_stD[d]; r.stallE = o_stE[d];
    r.flushD = o_flD[d]; r.flushE = o_flE[d]; r.flushM = o_flM[d];
    r.busy = o_busy[d]; r.done = o_done[d];
    r.cnt = {{(32-CNTW){1'b0}}, o_cnt[d]};
    return r;
  endfunction

  task automatic compare(int d, resp_t e);
    resp_t a;
    string p;
    a = sample(d);
    p = (d == 0) ? "lat1" : "lat2";
    check({p, " forwardAD"},    32'(a.fAD),    32'(e.fAD));
    check({p, " forwardBD"},    32'(a.fBD),    32'(e.fBD));
    check({p, " forwardAE"},    32'(a.fAE),    32'(e.fAE));
    check({p, " forwardBE"},    32'(a.fBE),    32'(e.fBE));
    check({p, " forwardHiloE"}, 32'(a.fH),     32'(e.fH));
    check({p, " stallF"},       32'(a.stallF), 32'(e.stallF));
    check({p, " stallD"},       32'(a.stallD), 32'(e.stallD));
    check({p, " stallE"},       32'(a.stallE), 32'(e.stallE));
    check({p, " flushD"},       32'(a.flushD), 32'(e.flushD));
    check({p, " flushE"},       32'(a.flushE), 32'(e.flushE));
    check({p, " flushM"},       32'(a.flushM), 32'(e.flushM));
    check({p, " div_busy"},     32'(a.busy),   32'(e.busy));
    check({p, " div_done"},     32'(a.done),   32'(e.done));
    check({p, " stall_cnt"},    a.cnt,         e.cnt);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q0.size() > 0) compare(0, exp_q0.pop_front());
      if (exp_q1.size() > 0) compare(1, exp_q1.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    bit prev_div;
    model_reset();
    set_inputs(zero_stim());

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset stall_cnt", 32'(o_cnt[d]), 32'd0);
      check("reset div_busy",  32'(o_busy[d]), 32'd0);
      check("reset div_done",  32'(o_done[d]), 32'd0);
    end
    rst = 1'b0;
    cyc_end();

    // Forwarding priority
    s = zero_stim();
    s.rsE = 5; s.rtE = 5; s.writeRegM = 5; s.writeRegW = 5;
    s.regWriteM = 1; s.regWriteW = 1;
    cyc_begin(s);
    check("fwd M prio AE", 32'(o_fAE[0]), 32'd2);
    check("fwd M prio BE", 32'(o_fBE[0]), 32'd2);
    cyc_end();
    s.regWriteM = 0;
    cyc_begin(s);
    check("fwd W AE", 32'(o_fAE[0]), 32'd1);
    check("fwd W BE", 32'(o_fBE[0]), 32'd1);
    cyc_end();
    s.rsE = 0;
    cyc_begin(s);
    check("fwd zero reg AE", 32'(o_fAE[0]), 32'd0);
    check("fwd rt still W",  32'(o_fBE[0]), 32'd1);
    cyc_end();

    // Load-use: load in E, then the same load in M
    s = zero_stim();
    s.memToRegE = 1; s.regWriteE = 1; s.rtE = 8; s.writeRegE = 8; s.rsD = 8;
    cyc_begin(s);
    for (int d = 0; d < 2; d++) begin
      check("lw E stallF", 32'(o_stF[d]), 32'd1);
      check("lw E stallD", 32'(o_stD[d]), 32'd1);
      check("lw E flushE", 32'(o_flE[d]), 32'd1);
    end
    cyc_end();
    s = zero_stim();
    s.memToRegM = 1; s.regWriteM = 1; s.writeRegM = 8; s.rsD = 8;
    cyc_begin(s);
    check("lw M lat1 stallF", 32'(o_stF[0]), 32'd0);
    check("lw M lat2 stallF", 32'(o_stF[1]), 32'd1);
    check("lw M lat2 flushE", 32'(o_flE[1]), 32'd1);
    cyc_end();
    cyc_begin(zero_stim());
    check("lw lat1 stall_cnt", 32'(o_cnt[0]), 32'd1);
    check("lw lat2 stall_cnt", 32'(o_cnt[1]), 32'd2);
    cyc_end();

    // Divide with a load-use hazard held alongside
    s = zero_stim();
    s.div_startE = 1; s.memToRegE = 1; s.rtE = 8; s.rsD = 8;
    for (int i = 0; i < DIVC; i++) begin
      cyc_begin(s);
      check("div stallE",   32'(o_stE[0]),  32'd1);
      check("div flushE",   32'(o_flE[0]),  32'd0);
      check("div busy",     32'(o_busy[0]), (i == 0) ? 32'd0 : 32'd1);
      check("div no done",  32'(o_done[0]), 32'd0);
      cyc_end();
    end
    s.memToRegE = 0;
    cyc_begin(s);
    check("div done pulse",  32'(o_done[0]), 32'd1);
    check("div done stallE", 32'(o_stE[0]),  32'd0);
    cyc_end();
    cyc_begin(zero_stim());
    check("div done cleared", 32'(o_done[0]), 32'd0);
    cyc_end();

    // Exception in the second BUSY cycle
    s = zero_stim();
    s.div_startE = 1;
    cyc_begin(s); cyc_end();
    cyc_begin(s); cyc_end();
    s.excM = 1;
    cyc_begin(s);
    check("exc stallF", 32'(o_stF[0]), 32'd0);
    check("exc stallE", 32'(o_stE[0]), 32'd0);
    check("exc flushD", 32'(o_flD[0]), 32'd1);
    check("exc flushE", 32'(o_flE[0]), 32'd1);
    check("exc flushM", 32'(o_flM[0]), 32'd1);
    cyc_end();
    for (int i = 0; i < 2; i++) begin
      cyc_begin(zero_stim());
      check("post exc busy", 32'(o_busy[0]), 32'd0);
      check("post exc done", 32'(o_done[0]), 32'd0);
      cyc_end();
    end

    // Saturation
    s = zero_stim();
    s.memToRegE = 1; s.rtE = 3; s.rtD = 3;
    repeat (20) begin
      cyc_begin(s); cyc_end();
    end
    cyc_begin(s);
    check("sat lat1 stall_cnt", 32'(o_cnt[0]), 32'(CMAX));
    check("sat lat2 stall_cnt", 32'(o_cnt[1]), 32'(CMAX));
    cyc_end();

    // Asynchronous reset mid-divide
    s = zero_stim();
    s.div_startE = 1;
    cyc_begin(s); cyc_end();
    cyc_begin(s); cyc_end();
    cyc_begin(s);
    #1;
    rst = 1'b1;
    #1;
    check("async rst stall_cnt", 32'(o_cnt[0]),  32'd0);
    check("async rst div_busy",  32'(o_busy[0]), 32'd0);
    model_reset();
    set_inputs(zero_stim());
    @(negedge clk);
    rst = 1'b0;
    cyc_end();
    for (int i = 0; i < DIVC; i++) begin
      cyc_begin(zero_stim());
      check("rst no done pulse", 32'(o_done[0]), 32'd0);
      cyc_end();
    end

    // Randomised traffic
    prev_div = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 499) reset_pulse();
      s.rsD = 5'($urandom_range(0, 7));
      s.rtD = 5'($urandom_range(0, 7));
      s.rsE = 5'($urandom_range(0, 7));
      s.rtE = 5'($urandom_range(0, 7));
      s.writeRegE = 5'($urandom_range(0, 7));
      s.writeRegM = 5'($urandom_range(0, 7));
      s.writeRegW = 5'($urandom_range(0, 7));
      s.branchD   = 1'($urandom_range(0, 3) == 0);
      s.regWriteE = 1'($urandom_range(0, 1));
      s.memToRegE = 1'($urandom_range(0, 3) == 0);
      s.regWriteM = 1'($urandom_range(0, 1));
      s.memToRegM = 1'($urandom_range(0, 3) == 0);
      s.hilo_weM  = 1'($urandom_range(0, 1));
      s.regWriteW = 1'($urandom_range(0, 1));
      s.hilo_weW  = 1'($urandom_range(0, 1));
      s.excM      = 1'($urandom_range(0, 24) == 0);
      s.div_startE = prev_div ? 1'($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 5) == 0);
      prev_div = s.div_startE;
      apply(s);
      cyc_end();
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) begin
      @(negedge clk);
    end
    #1;
    check("scoreboard drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
